rv32_mem_initiator: RTL and testbench
=====================================

RV32_MEM_INITIATOR -- requirements
Module: rv32_mem_initiator

Interface
REQ-001 Parameter: L, default 128; depth of the attached RAM in 32-bit words. Memory address width AW = $clog2(L).
REQ-002 Port: clk, input, 1; single clock, all state updates on the rising edge.
REQ-003 Port: rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 Port: req_valid, input, 1; the core presents a load/store request.
REQ-005 Port: req_ready, output, 1; the block accepts the request.
REQ-006 Port: req_write, input, 1; 1 = store, 0 = load.
REQ-007 Port: req_funct3, input, 3; RV32I width code: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
REQ-008 Port: req_addr, input, 32; byte address.
REQ-009 Port: req_wdata, input, 32; store data, right-aligned.
REQ-010 Port: rsp_valid, output, 1; the response is available.
REQ-011 Port: rsp_ready, input, 1; the core consumes the response.
REQ-012 Port: rsp_rdata, output, 32; load result, extended to 32 bits.
REQ-013 Port: rsp_error, output, 1; the access was misaligned, out of range, or had an illegal funct3.
REQ-014 Port: mem_addr, output, AW; RAM word index.
REQ-015 Port: mem_wr_ena, output, 1; RAM write strobe.
REQ-016 Port: mem_wr_data, output, 32; RAM write word.
REQ-017 Port: mem_rd_data, input, 32; combinational (asynchronous) RAM read data.

Function
REQ-018 The block SHALL implement the FSM states IDLE, READ, WRITE and RESP, with exactly one request outstanding at a time.
REQ-019 In IDLE, req_ready SHALL be 1; req_ready SHALL be 0 in every other state.
REQ-020 On the edge where req_valid=1 in IDLE, the block SHALL capture write, funct3, addr and wdata, and SHALL go to READ.
REQ-021 mem_addr SHALL equal the captured addr[AW+1:2] in every state.
REQ-022 In READ, the block SHALL register mem_rd_data and SHALL classify the request as an error if any of the following holds: addr[31:2] >= L; a halfword access with addr[0]=1; a word access with addr[1:0]!=0; a load funct3 in {3,6,7}; a store funct3 > 2.
REQ-023 From READ, the FSM SHALL go to RESP on an error or a load, and SHALL go to WRITE on a legal store.
REQ-024 Loads: byte lane = addr[1:0] and halfword lane = addr[1]. LB and LH SHALL sign-extend. LBU and LHU SHALL zero-extend. LW SHALL pass the word through.
REQ-025 Stores: mem_wr_data SHALL be the read word with only the addressed byte or halfword lane replaced by req_wdata[7:0] or req_wdata[15:0]. SW SHALL replace the whole word.
REQ-026 mem_wr_ena SHALL be 1 for exactly the single WRITE cycle and 0 in all other states; an erroneous store SHALL never write.
REQ-027 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_error SHALL stay stable until rsp_ready=1. The FSM SHALL then return to IDLE on that edge.
REQ-028 rsp_rdata SHALL be 0 for stores and for errors.
REQ-029 Latency, with acceptance at edge N: a load SHALL assert rsp_valid after edge N+1, and a store after edge N+2, provided rsp_ready is held at 1.
REQ-030 With rsp_ready=0, the block SHALL remain in RESP indefinitely and SHALL accept no new request.
REQ-031 The response handshake and the next request SHALL NOT overlap: a new request can be accepted no earlier than the cycle after rsp_valid&rsp_ready.

Reset
REQ-032 When rst_n=0, the block SHALL immediately and asynchronously enter IDLE with all of the following: req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, mem_wr_ena=0, mem_addr=0, mem_wr_data=0, and all captured registers 0.
REQ-033 Reset during READ, WRITE or RESP SHALL drop the in-flight request with no RAM write; mem_wr_ena SHALL fall combinationally with rst_n.
REQ-034 Operation SHALL resume on the first rising edge after rst_n is released.

Verification
REQ-035 RAM[3]=0x8000_7FF0; LB at addr 0x0C -> rsp_rdata=0xFFFF_FFF0 at N+2. LBU at 0x0F -> 0x0000_0080. LH at 0x0E -> 0xFFFF_8000.
REQ-036 RAM[5]=0x1122_3344; SB at 0x15 with wdata 0xAB -> a single mem_wr_ena pulse with mem_wr_data=0x1122_AB44 and mem_addr=5, then rsp_valid at N+3 with rsp_rdata=0.
REQ-037 Each of the following -> rsp_error=1, rsp_rdata=0, and no mem_wr_ena pulse: LW at 0x06; SH at 0x03; LW at 0x200 with L=128; load funct3=3.
REQ-038 Load issued with rsp_ready=0 for 5 cycles -> rsp_valid held high and rsp_rdata stable, req_ready=0 throughout; RESP exits on the edge where rsp_ready=1, and req_ready=1 on the next cycle.
REQ-039 rst_n driven low mid-cycle during WRITE of an SW -> mem_wr_ena drops immediately, the RAM word is unchanged, and all outputs are at their reset values.
REQ-040 Back-to-back SW 0xDEAD_BEEF to 0x08 then LW from 0x08 -> the load returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/rv32_mem_initiator.sv
// rv32_mem_initiator: turns one RV32I load/store request at a time into
// read-modify-write accesses on a word-wide RAM with asynchronous read data.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_write, req_funct3      store/load select, RV32I width code
//   req_addr, req_wdata        byte address, right-aligned store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_error       extended load data, error flag
//   mem_addr, mem_wr_ena,      RAM word index, write strobe,
//   mem_wr_data, mem_rd_data   write word, combinational read word
module rv32_mem_initiator #(
  parameter  int unsigned L  = 128,
  localparam int unsigned AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_ena,
  output logic [31:0]   mem_wr_data,
  input  logic [31:0]   mem_rd_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        err_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;
  logic [7:0]  rd_byte_c;
  logic [15:0] rd_half_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = READ;
      READ:  state_d = (err_c || !write_q) ? RESP : WRITE;
      WRITE: state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the state register, so they
  // follow the asynchronous reset without waiting for a clock edge
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_wr_ena = 1'b0;
    case (state_q)
      IDLE:  req_ready  = 1'b1;
      WRITE: mem_wr_ena = 1'b1;
      RESP:  rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = addr_q[AW+1:2];

  // Legality: range, alignment for halfword/word widths, and funct3 codes
  always_comb begin
    logic oor, half_mis, word_mis, bad_f3;
    oor      = (32'(addr_q[31:2]) >= L);
    half_mis = (funct3_q[1:0] == 2'b01) && addr_q[0];
    word_mis = (funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00);
    bad_f3   = write_q ? (funct3_q > 3'd2)
                       : ((funct3_q == 3'd3) || (funct3_q[2:1] == 2'b11));
    err_c    = oor || half_mis || word_mis || bad_f3;
  end

  // Load lane extraction and extension
  always_comb begin
    rd_byte_c = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
    rd_half_c = mem_rd_data[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_c = {{24{rd_byte_c[7]}}, rd_byte_c};
      3'd1:    load_c = {{16{rd_half_c[15]}}, rd_half_c};
      3'd2:    load_c = mem_rd_data;
      3'd4:    load_c = {24'd0, rd_byte_c};
      3'd5:    load_c = {16'd0, rd_half_c};
      default: load_c = 32'd0;
    endcase
  end

  // Store merge: replace only the addressed lane of the current word
  always_comb begin
    merge_c = mem_rd_data;
    case (funct3_q[1:0])
      2'b00:   merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merge_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_c = wdata_q;
    endcase
  end

  // Request capture and response/write-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_rdata   <= 32'd0;
      rsp_error   <= 1'b0;
      mem_wr_data <= 32'd0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == READ) begin
        rsp_rdata   <= (err_c || write_q) ? 32'd0 : load_c;
        rsp_error   <= err_c;
        mem_wr_data <= merge_c;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_initiator.sv
// Randomized bench for rv32_mem_initiator with a byte-level reference model
// and a behavioural RAM.
module tb_rv32_mem_initiator;
  localparam int unsigned L  = 128;
  localparam int unsigned AW = $clog2(L);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_ena;
  logic [31:0]   mem_wr_data, mem_rd_data;

  logic [31:0]   ram [L];
  int            checks = 0;
  int            failures = 0;
  int            wr_count = 0;
  logic [31:0]   last_wr_data;
  logic [AW-1:0] last_wr_addr;

  rv32_mem_initiator #(.L(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_ena) begin
      ram[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
      last_wr_data  <= mem_wr_data;
      last_wr_addr  <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: what the access should return and do to RAM, from byte rules
  function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd,
                                output bit does_wr, output logic [31:0] new_word);
    int unsigned bytes, sh, idx;
    logic [31:0] word, mask, v;
    idx   = a / 4;
    sh    = 8 * (a % 4);
    bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    word  = (idx < L) ? ram[idx] : 32'd0;
    err   = (idx >= L) || (a % bytes != 0);
    if (!wr && (f3 == 3 || f3 == 6 || f3 == 7)) err = 1;
    if (wr && f3 > 2) err = 1;
    rd = 0; does_wr = 0; new_word = word;
    mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 1);
    if (err) return;
    if (wr) begin
      does_wr  = 1;
      new_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      v = (word >> sh) & mask;
      if (bytes < 4 && f3 < 4 && v[8*bytes-1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input string tag,
                        output logic [31:0] obs_rd, output logic obs_err);
    bit          e_err, e_wr;
    logic [31:0] e_rd, e_word;
    int          wc0, lat;
    model(wr, f3, a, wd, e_err, e_rd, e_wr, e_word);
    wc0 = wr_count;
    @(negedge clk);
    rsp_ready = (hold == 0);
    req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk({tag, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), (wr && !e_err) ? 32'd3 : 32'd2);
    chk({tag, ":rdata"}, rsp_rdata, e_rd);
    chk({tag, ":error"}, 32'(rsp_error), 32'(e_err));
    chk({tag, ":req_ready_resp"}, 32'(req_ready), 32'd0);
    obs_rd = rsp_rdata; obs_err = rsp_error;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ":hold_rdata"}, rsp_rdata, e_rd);
        chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1;
    end
    @(negedge clk);
    chk({tag, ":valid_after"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ":wr_pulses"}, 32'(wr_count - wc0), 32'(e_wr));
    if (e_wr) begin
      chk({tag, ":wr_data"}, last_wr_data, e_word);
      chk({tag, ":wr_addr"}, 32'(last_wr_addr), a / 4);
      chk({tag, ":ram"}, ram[a / 4], e_word);
    end
  endtask

  initial begin
    logic [31:0] rd, saved, wd, a;
    logic        er;
    int          wc0;
    bit          w;
    logic [2:0]  f3;
    for (int i = 0; i < int'(L); i++) ram[i] = $urandom;
    rst_n = 0; req_valid = 0; req_write = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1;
    #2;
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_error", 32'(rsp_error), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:mem_wr_ena", 32'(mem_wr_ena), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    chk("rst:mem_wr_data", mem_wr_data, 32'd0);
    @(negedge clk); rst_n = 1;

    // Directed loads
    ram[3] = 32'h8000_7FF0;
    do_req(0, 3'd0, 32'h0C, 0, 0, "lb_0c", rd, er);  chk("lb_0c:val", rd, 32'hFFFF_FFF0);
    do_req(0, 3'd4, 32'h0F, 0, 0, "lbu_0f", rd, er); chk("lbu_0f:val", rd, 32'h0000_0080);
    do_req(0, 3'd1, 32'h0E, 0, 0, "lh_0e", rd, er);  chk("lh_0e:val", rd, 32'hFFFF_8000);

    // Directed byte store
    ram[5] = 32'h1122_3344;
    do_req(1, 3'd0, 32'h15, 32'h0000_00AB, 0, "sb_15", rd, er);
    chk("sb_15:ram", ram[5], 32'h1122_AB44);
    chk("sb_15:rdata", rd, 32'd0);

    // Directed errors
    do_req(0, 3'd2, 32'h06, 0, 0, "lw_06", rd, er);   chk("lw_06:err", 32'(er), 32'd1);
    do_req(1, 3'd1, 32'h03, 32'h1234, 0, "sh_03", rd, er); chk("sh_03:err", 32'(er), 32'd1);
    do_req(0, 3'd2, 32'h200, 0, 0, "lw_200", rd, er); chk("lw_200:err", 32'(er), 32'd1);
    do_req(0, 3'd3, 32'h10, 0, 0, "ld_f3", rd, er);   chk("ld_f3:err", 32'(er), 32'd1);

    // Response back-pressure
    do_req(0, 3'd2, 32'h0C, 0, 5, "hold", rd, er);

    // Reset during WRITE of an SW
    saved = ram[10];
    wc0   = wr_count;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'h28; req_wdata = ~saved;
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    chk("rstw:in_write", 32'(mem_wr_ena), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rstw:wr_ena", 32'(mem_wr_ena), 32'd0);
    chk("rstw:req_ready", 32'(req_ready), 32'd1);
    chk("rstw:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw:mem_addr", 32'(mem_addr), 32'd0);
    chk("rstw:mem_wr_data", mem_wr_data, 32'd0);
    chk("rstw:rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst_n = 1;
    chk("rstw:ram", ram[10], saved);
    chk("rstw:no_write", 32'(wr_count - wc0), 32'd0);

    // Store then load round trip
    do_req(1, 3'd2, 32'h08, 32'hDEAD_BEEF, 0, "sw_08", rd, er);
    do_req(0, 3'd2, 32'h08, 0, 0, "lw_08", rd, er);
    chk("lw_08:val", rd, 32'hDEAD_BEEF);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * L - 1));
      wd = $urandom;
      do_req(w, f3, a, wd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
             $sformatf("rnd%0d", i), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
